// File: rtl/pes_ram_io_sequencer_if.sv
// RAM-side bus of the self-test sequencer: write port plus registered read data.
interface pes_ram_io_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  modport master (
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/pes_ram_io_sequencer.sv
// RAM self-test sequencer: fills the RAM with an LFSR pattern, reads it back,
// shows each word on the pad bus for HOLD cycles and counts mismatches.
module pes_ram_io_sequencer #(
  parameter int unsigned AW        = 4,
  parameter int unsigned HOLD      = 4,
  parameter logic [15:0] SEED      = 16'h372C,
  parameter logic [15:0] IDLE_WORD = 16'h2100
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  pes_ram_io_sequencer_if.master   ram,
  output logic [15:0]              io_out,
  output logic [15:0]              io_oeb,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               mismatch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_SHOW,
    S_DONE
  } state_t;

  localparam int unsigned   HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   io_q, io_d;
  logic [7:0]    mis_q, mis_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_q;
  logic          rise;

  assign rise = start & ~start_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lfsr_q  <= SEED;
      io_q    <= IDLE_WORD;
      mis_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
      io_q    <= io_d;
      mis_q   <= mis_d;
      hold_q  <= hold_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    io_d    = io_q;
    mis_d   = mis_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_IDLE) io_d = IDLE_WORD;
        // DONE restarts exactly like IDLE but leaves the last word on the pads
        if (rise) begin
          addr_d  = '0;
          lfsr_d  = SEED;
          mis_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          lfsr_d  = SEED;
          state_d = S_READ_REQ;
        end else begin
          addr_d = addr_q + 1'b1;
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      S_READ_REQ: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        io_d = ram.ram_rdata;
        if (ram.ram_rdata != lfsr_q && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
        hold_d  = HOLD_LOAD;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (hold_q == '0) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            lfsr_d  = lfsr_step(lfsr_q);
            state_d = S_READ_REQ;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram.ram_we    = (state_q == S_WRITE);
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = lfsr_q;
  assign io_out        = io_q;
  assign io_oeb        = '0;
  assign busy          = (state_q == S_WRITE) || (state_q == S_READ_REQ) ||
                         (state_q == S_READ_WAIT) || (state_q == S_SHOW);
  assign done          = (state_q == S_DONE);
  assign error         = |mis_q;
  assign mismatch_cnt  = mis_q;

endmodule

// File: tb/tb_pes_ram_io_sequencer.sv
// Self-checking bench for pes_ram_io_sequencer: cycle-by-cycle comparison of
// the pad/RAM outputs against a timeline computed from the pattern list.
module tb_pes_ram_io_sequencer;

  localparam int          AW        = 4;
  localparam int          DEPTH     = 1 << AW;
  localparam int          HOLD      = 4;
  localparam int          WORD_CYC  = 2 + HOLD;
  localparam int          RUN_LEN   = DEPTH + DEPTH * WORD_CYC;
  localparam logic [15:0] SEED      = 16'h372C;
  localparam logic [15:0] IDLE_WORD = 16'h2100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0] io_out, io_oeb;
  logic busy, done, error;
  logic [7:0] mismatch_cnt;

  always #5 clk = ~clk;

  pes_ram_io_sequencer_if #(.AW(AW)) ram_bus ();

  pes_ram_io_sequencer #(
    .AW(AW), .HOLD(HOLD), .SEED(SEED), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .ram(ram_bus),
    .io_out(io_out), .io_oeb(io_oeb), .busy(busy), .done(done),
    .error(error), .mismatch_cnt(mismatch_cnt)
  );

  // RAM with 1-cycle registered read; optionally flips bit 0 of one address
  logic [15:0] mem [DEPTH];
  int fault_addr = -1;
  always @(posedge clk) begin
    if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
    ram_bus.ram_rdata <= mem[ram_bus.ram_addr] ^
                         ((int'(ram_bus.ram_addr) == fault_addr) ? 16'h0001 : 16'h0000);
  end

  // Reference: the expected pattern list and the run timeline derived from it
  logic [15:0] pat [DEPTH];
  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] last_word;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return (v << 1) | {15'd0, fb};
  endfunction

  function automatic logic [15:0] exp_word(input int j);
    return pat[j] ^ ((j == fault_addr) ? 16'h0001 : 16'h0000);
  endfunction

  function automatic int word_index(input int k);
    int j;
    j = (k - DEPTH) / WORD_CYC;
    return (j > DEPTH - 1) ? DEPTH - 1 : j;
  endfunction

  function automatic logic [15:0] exp_io(input int k, input logic [15:0] prev);
    int j;
    if (k < DEPTH + 2) return prev;
    j = (k - DEPTH - 2) / WORD_CYC;
    if (j > DEPTH - 1) j = DEPTH - 1;
    return exp_word(j);
  endfunction

  function automatic int exp_addr(input int k);
    return (k < DEPTH) ? k : word_index(k);
  endfunction

  function automatic int exp_mis(input int k);
    int n;
    n = 0;
    for (int j = 0; j < DEPTH; j++)
      if (j == fault_addr && k >= DEPTH + WORD_CYC * j + 2) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_values();
    chk("rst_io_out", 32'(io_out), 32'(IDLE_WORD));
    chk("rst_io_oeb", 32'(io_oeb), 32'h0);
    chk("rst_ram_we", 32'(ram_bus.ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_bus.ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_bus.ram_wdata), 32'(SEED));
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_mismatch", 32'(mismatch_cnt), 32'h0);
  endtask

  // Checks offsets k_from..k_to-1 (k = 0 is the first WRITE cycle), one per negedge
  task automatic run_phase(input int k_from, input int k_to,
                           input logic [15:0] prev, input bit glitch);
    for (int k = k_from; k < k_to; k++) begin
      if (k != k_from) @(negedge clk);
      chk($sformatf("ram_we k=%0d", k), 32'(ram_bus.ram_we), 32'(k < DEPTH));
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'(k < RUN_LEN));
      chk($sformatf("done k=%0d", k), 32'(done), 32'(k >= RUN_LEN));
      chk($sformatf("ram_addr k=%0d", k), 32'(ram_bus.ram_addr), 32'(exp_addr(k)));
      chk($sformatf("ram_wdata k=%0d", k), 32'(ram_bus.ram_wdata), 32'(pat[exp_addr(k)]));
      chk($sformatf("io_out k=%0d", k), 32'(io_out), 32'(exp_io(k, prev)));
      chk($sformatf("mismatch k=%0d", k), 32'(mismatch_cnt), 32'(exp_mis(k)));
      chk($sformatf("error k=%0d", k), 32'(error), 32'(exp_mis(k) != 0));
      chk($sformatf("io_oeb k=%0d", k), 32'(io_oeb), 32'h0);
      if (glitch) start = (k > 0 && k < 100 && $urandom_range(0, 7) == 0);
    end
    if (glitch) start = 1'b0;
  endtask

  task automatic kick(input bit hold_high);
    bit found;
    found = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      found = (ram_bus.ram_we === 1'b1);
    end
    chk("start_to_write", 32'(found), 32'h1);
    if (!hold_high) start = 1'b0;
  endtask

  initial begin
    pat[0] = SEED;
    for (int i = 1; i < DEPTH; i++) pat[i] = model_step(pat[i-1]);

    // Asynchronous reset asserted between edges
    #12 rst = 1'b1;
    #1 check_reset_values();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Normal run, first written word is the seed and the second its successor
    kick(1'b0);
    chk("first_wdata", 32'(ram_bus.ram_wdata), 32'h372C);
    @(negedge clk);
    chk("second_wdata", 32'(ram_bus.ram_wdata), 32'h6E59);
    run_phase(1, RUN_LEN + 3, IDLE_WORD, 1'b0);
    last_word = exp_word(DEPTH - 1);

    // Fault at address 5, restarted from DONE
    fault_addr = 5;
    kick(1'b0);
    run_phase(0, RUN_LEN + 3, last_word, 1'b0);
    last_word = exp_word(DEPTH - 1);

    // Random fault address with stray start pulses while busy
    fault_addr = int'($urandom_range(0, DEPTH - 1));
    kick(1'b0);
    run_phase(0, RUN_LEN + 3, last_word, 1'b1);
    last_word = exp_word(DEPTH - 1);

    // Start held high: one run only, then a fresh rising edge runs again
    fault_addr = -1;
    kick(1'b1);
    run_phase(0, RUN_LEN + 8, last_word, 1'b0);
    last_word = exp_word(DEPTH - 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_done_stays", 32'(done), 32'h1);
    kick(1'b0);
    run_phase(0, RUN_LEN + 2, last_word, 1'b0);

    // Reset during SHOW of word 7, then a clean full run
    fault_addr = 9;
    kick(1'b0);
    run_phase(0, DEPTH + WORD_CYC * 7 + 3, exp_word(DEPTH - 1), 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(negedge clk) rst = 1'b0;
    fault_addr = -1;
    @(negedge clk);
    kick(1'b0);
    run_phase(0, RUN_LEN + 2, IDLE_WORD, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
